// File: rtl/sbox_array.sv
// sbox_array: two-stage pipelined multi-lane AES SubBytes / InvSubBytes with valid/ready handshakes.
// Activity counters (perf_clr, perf_xfers, perf_stalls) are compiled in when SBOX_PERF_EN is defined.
module sbox_array #(
    parameter  int unsigned LANES = 4,
    localparam int unsigned DW    = 8 * LANES
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef SBOX_PERF_EN
    input  logic          perf_clr,
    output logic [15:0]   perf_xfers,
    output logic [15:0]   perf_stalls,
`endif
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_inv,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_inv,
    output logic [DW-1:0] out_data
);

    function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Shift-and-add multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ t;
            end
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 == a^-1 for a != 0, and 0 maps to 0 without a special case.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2;
        logic [7:0] a3;
        logic [7:0] a6;
        logic [7:0] a12;
        logic [7:0] a15;
        logic [7:0] a240;
        logic [7:0] a252;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a6   = gf_mul(a3, a3);
        a12  = gf_mul(a6, a6);
        a15  = gf_mul(a12, a3);
        a240 = a15;
        for (int i = 0; i < 4; i++) begin
            a240 = gf_mul(a240, a240);
        end
        a252 = gf_mul(a240, a12);
        return gf_mul(a252, a2);
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] b);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05;
    endfunction

    logic          s1_valid;
    logic          s1_inv;
    logic [DW-1:0] s1_data;
    logic          s2_valid;
    logic          s2_inv;
    logic [DW-1:0] s2_data;

    logic          s1_adv;
    logic          s2_adv;
    logic          accept;
    logic [DW-1:0] pre;
    logic [DW-1:0] post;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && s1_adv;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [7:0] lane_in;
        logic [7:0] lane_s1;
        logic [7:0] lane_inv;

        assign lane_in          = in_data[8*k +: 8];
        assign lane_s1          = s1_data[8*k +: 8];
        assign pre[8*k +: 8]    = in_inv ? inv_affine(lane_in) : lane_in;
        assign lane_inv         = gf_inv(lane_s1);
        assign post[8*k +: 8]   = s1_inv ? lane_inv : fwd_affine(lane_inv);
    end

    // Data registers only load on a real transfer so idle-bus X never reaches out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_inv   <= 1'b0;
            s1_data  <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_inv  <= in_inv;
                s1_data <= pre;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_inv   <= 1'b0;
            s2_data  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_inv  <= s1_inv;
                s2_data <= post;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_inv   = s2_inv;
    assign out_data  = s2_data;

`ifdef SBOX_PERF_EN
    logic xfer_evt;
    logic stall_evt;

    assign xfer_evt  = out_valid && out_ready;
    assign stall_evt = in_valid && !in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_xfers  <= 16'h0000;
            perf_stalls <= 16'h0000;
        end else if (perf_clr) begin
            perf_xfers  <= 16'h0000;
            perf_stalls <= 16'h0000;
        end else begin
            if (xfer_evt && (perf_xfers != 16'hFFFF)) begin
                perf_xfers <= perf_xfers + 16'd1;
            end
            if (stall_evt && (perf_stalls != 16'hFFFF)) begin
                perf_stalls <= perf_stalls + 16'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid && !out_ready |=> out_valid && $stable(out_data) && $stable(out_inv));

    a_accept_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !s1_valid |-> in_ready);
`endif

endmodule

// File: tb/tb_sbox_array.sv
// Randomised and directed bench for sbox_array, checked against an arithmetic GF(2^8) S-box model.
module tb_sbox_array;
`ifdef SBOX_PERF_EN
    localparam int LANES = 16;
`else
    localparam int LANES = 4;
`endif
    localparam int DW = 8 * LANES;

    typedef struct {
        logic [DW-1:0] data;
        logic          inv;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_inv = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_inv;
    logic [DW-1:0] out_data;
`ifdef SBOX_PERF_EN
    logic          perf_clr = 1'b0;
    logic [15:0]   perf_xfers;
    logic [15:0]   perf_stalls;
`endif

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int accepts = 0;
    int outs = 0;
    int fwd_tab[256];
    int inv_tab[256];
    txn_t exp_q[$];
    int out_cyc[$];

    logic          prev_stall = 1'b0;
    logic          prev_inv;
    logic [DW-1:0] prev_data;

    sbox_array #(.LANES(LANES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef SBOX_PERF_EN
        .perf_clr   (perf_clr),
        .perf_xfers (perf_xfers),
        .perf_stalls(perf_stalls),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inv     (in_inv),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inv    (out_inv),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Polynomial product then reduction by 0x11B, bit by bit from the top.
    function automatic int gmul(input int a, input int b);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++) begin
            if (((b >> i) & 1) == 1) p = p ^ (a << i);
        end
        for (int i = 15; i >= 8; i--) begin
            if (((p >> i) & 1) == 1) p = p ^ ('h11b << (i - 8));
        end
        return p;
    endfunction

    function automatic int rot8(input int b, input int n);
        return ((b << n) | (b >> (8 - n))) & 'hff;
    endfunction

    function automatic void build_tables();
        int inv;
        int s;
        for (int b = 0; b < 256; b++) begin
            inv = 0;
            for (int x = 1; x < 256; x++) begin
                if (gmul(b, x) == 1) inv = x;
            end
            s = inv ^ rot8(inv, 1) ^ rot8(inv, 2) ^ rot8(inv, 3) ^ rot8(inv, 4) ^ 'h63;
            fwd_tab[b] = s;
            inv_tab[s] = b;
        end
    endfunction

    function automatic txn_t model(input logic [DW-1:0] d, input logic inv);
        txn_t t;
        for (int k = 0; k < LANES; k++) begin
            t.data[8*k +: 8] = inv ? 8'(inv_tab[d[8*k +: 8]]) : 8'(fwd_tab[d[8*k +: 8]]);
        end
        t.inv = inv;
        return t;
    endfunction

    function automatic logic [DW-1:0] rep(input logic [31:0] v);
        logic [DW-1:0] r;
        for (int k = 0; k < LANES; k++) r[8*k +: 8] = v[8*(k % 4) +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int k = 0; k < LANES; k++) r[8*k +: 8] = 8'($urandom_range(0, 255));
        return r;
    endfunction

    // Inputs change #1 after posedge, so the negedge view predicts the next edge's handshakes.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            txn_t t;
            cycle++;
            if (prev_stall) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_hold", {out_inv, out_data}, {prev_inv, prev_data});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", out_valid, 1'b0);
                end else begin
                    t = exp_q.pop_front();
                    check("out_data", out_data, t.data);
                    check("out_inv", out_inv, t.inv);
                end
                outs++;
                out_cyc.push_back(cycle);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_data, in_inv));
                accepts++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_inv   = out_inv;
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic inv);
        int waited;
        waited = 0;
        in_data  = d;
        in_inv   = inv;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("send_accept", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic directed(input string tag, input logic [31:0] vin, input logic inv,
                            input logic [31:0] vexp);
        out_ready = 1'b1;
        in_data   = rep(vin);
        in_inv    = inv;
        in_valid  = 1'b1;
        @(negedge clk);
        check({tag, "_ready"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat1"}, out_valid, 1'b0);
        @(negedge clk);
        check({tag, "_lat2"}, out_valid, 1'b1);
        check({tag, "_data"}, out_data, rep(vexp));
        check({tag, "_inv"}, out_inv, inv);
        @(posedge clk);
        #1;
    endtask

    task automatic hold_input(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = rand_data();
            in_inv   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0;
        int o0;
        int n;
        logic [DW-1:0] d;

        build_tables();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_out_inv", out_inv, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
`ifdef SBOX_PERF_EN
        check("rst_perf_xfers", perf_xfers, 16'h0000);
        check("rst_perf_stalls", perf_stalls, 16'h0000);
`endif
        @(posedge clk);
        #1;

        directed("fips_fwd", 32'h000153FF, 1'b0, 32'h637CED16);
        directed("fips_inv", 32'h637CED16, 1'b1, 32'h000153FF);
        directed("fips_col0", 32'h10203040, 1'b0, 32'hCAB70409);

        // Every byte value forward, then the model's forward images back through the inverse.
        out_ready = 1'b1;
        for (int i = 0; i < 256; i += LANES) begin
            for (int k = 0; k < LANES; k++) d[8*k +: 8] = 8'((i + k) % 256);
            send(d, 1'b0);
        end
        for (int i = 0; i < 256; i += LANES) begin
            for (int k = 0; k < LANES; k++) d[8*k +: 8] = 8'(fwd_tab[(i + k) % 256]);
            send(d, 1'b1);
        end
        drain();

        for (int i = 0; i < 8; i++) send(rand_data(), 1'(i % 2));
        drain();
        n = out_cyc.size();
        for (int i = n - 8; i < n - 1; i++) check("b2b_gap", out_cyc[i+1] - out_cyc[i], 1);

        // Backpressure: five cycles of offered input against a blocked sink.
        out_ready = 1'b0;
        a0 = accepts;
        o0 = outs;
        hold_input(5);
        @(negedge clk);
        check("bp_accepts", accepts - a0, 2);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_out_valid", out_valid, 1'b1);
        drain();
        check("bp_drained", outs - o0, 2);

        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_inv    = 1'($urandom_range(0, 1));
            in_data   = rand_data();
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();

        // Reset asserted between edges with two transactions in flight.
        out_ready = 1'b0;
        hold_input(2);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", out_data, '0);
        check("midrst_out_inv", out_inv, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_in_ready", in_ready, 1'b1);
        check("postrst_out_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        o0 = outs;
        repeat (4) @(negedge clk);
        check("postrst_no_stale", outs - o0, 0);
        @(posedge clk);
        #1;

`ifdef SBOX_PERF_EN
        perf_clr = 1'b1;
        @(posedge clk);
        #1;
        perf_clr = 1'b0;
        for (int i = 0; i < 10; i++) send(rand_data(), 1'(i % 2));
        drain();
        out_ready = 1'b0;
        hold_input(5);
        @(negedge clk);
        check("perf_xfers_10", perf_xfers, 16'd10);
        check("perf_stalls_3", perf_stalls, 16'd3);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        perf_clr = 1'b1;
        @(posedge clk);
        #1;
        perf_clr = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("perf_clr_xfers", perf_xfers, 16'h0000);
        check("perf_clr_stalls", perf_stalls, 16'h0000);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("perf_stalls_sat", perf_stalls, 16'hFFFF);
        check("perf_xfers_idle", perf_xfers, 16'h0000);
        drain();
`endif

        check("final_queue", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
